arc4_sched: RTL and testbench



---
 rtl/arc4_sched.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_arc4_sched.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_sched.sv
// arc4_sched: top-level sequencer for the ARC4 datapath.
// Runs the init, KSA and PRGA engines in order over the en/rdy handshake
// and routes the single-port S memory write port to the active engine.
// Each engine must acknowledge its start pulse within ACK_CYCLES cycles
// and must finish within WDOG_CYCLES busy cycles; otherwise the sequence
// aborts and raises a sticky err flag.

module arc4_sched #(
    parameter int WDOG_CYCLES = 65535,
    parameter int ACK_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic       err,
    output logic [1:0] phase,
    output logic       init_en,
    output logic       ksa_en,
    output logic       prga_en,
    input  logic       init_rdy,
    input  logic       ksa_rdy,
    input  logic       prga_rdy,
    input  logic [7:0] init_addr,
    input  logic [7:0] ksa_addr,
    input  logic [7:0] prga_addr,
    input  logic [7:0] init_wrdata,
    input  logic [7:0] ksa_wrdata,
    input  logic [7:0] prga_wrdata,
    input  logic       init_wren,
    input  logic       ksa_wren,
    input  logic       prga_wren,
    output logic [7:0] s_addr,
    output logic [7:0] s_wrdata,
    output logic       s_wren
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_ACK  = 3'd2,
        ST_BUSY = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // Stage, owner and phase share one encoding so phase can mirror the stage.
    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_INIT = 2'd1;
    localparam logic [1:0] SEL_KSA  = 2'd2;
    localparam logic [1:0] SEL_PRGA = 2'd3;

    // Last counter value allowed before the corresponding timeout fires.
    localparam logic [15:0] ACK_LAST  = 16'(ACK_CYCLES - 1);
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

    // Saturating 16-bit increment: the cycle counters must never wrap.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  stage_r;
    logic [1:0]  stage_nxt_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_nxt_s;

    logic        rdy_r;
    logic        rdy_nxt_s;
    logic        err_r;
    logic        err_nxt_s;
    logic [1:0]  phase_r;
    logic [1:0]  phase_nxt_s;
    logic [1:0]  owner_r;
    logic [1:0]  owner_nxt_s;
    logic        init_en_r;
    logic        init_en_nxt_s;
    logic        ksa_en_r;
    logic        ksa_en_nxt_s;
    logic        prga_en_r;
    logic        prga_en_nxt_s;

    logic        sel_rdy_s;
    logic        accept_s;
    logic        launch_s;

    assign rdy     = rdy_r;
    assign err     = err_r;
    assign phase   = phase_r;
    assign init_en = init_en_r;
    assign ksa_en  = ksa_en_r;
    assign prga_en = prga_en_r;

    // Ready flag of the engine selected by the current stage.
    always_comb begin
        sel_rdy_s = 1'b0;
        case (stage_r)
            SEL_INIT: sel_rdy_s = init_rdy;
            SEL_KSA:  sel_rdy_s = ksa_rdy;
            SEL_PRGA: sel_rdy_s = prga_rdy;
            default:  sel_rdy_s = 1'b0;
        endcase
    end

    // State, stage and cycle-counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            stage_r <= SEL_NONE;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            stage_r <= stage_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic: sequencing, handshake timeout and watchdog.
    always_comb begin
        state_nxt_s = state_r;
        stage_nxt_s = stage_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_nxt_s = ST_ARM;
                    stage_nxt_s = SEL_INIT;
                    cnt_nxt_s   = 16'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (sel_rdy_s) begin
                    state_nxt_s = ST_ACK;
                    cnt_nxt_s   = 16'd0;
                end else begin
                    state_nxt_s = ST_ARM;
                end
            end
            ST_ACK: begin
                if (!sel_rdy_s) begin
                    state_nxt_s = ST_BUSY;
                    cnt_nxt_s   = 16'd0;
                end else if (cnt_r >= ACK_LAST) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    cnt_nxt_s = sat_inc(cnt_r);
                end
            end
            ST_BUSY: begin
                // Completion is tested first so it wins over a same-cycle expiry.
                if (sel_rdy_s) begin
                    cnt_nxt_s = 16'd0;
                    case (stage_r)
                        SEL_INIT: begin
                            state_nxt_s = ST_ARM;
                            stage_nxt_s = SEL_KSA;
                        end
                        SEL_KSA: begin
                            state_nxt_s = ST_ARM;
                            stage_nxt_s = SEL_PRGA;
                        end
                        default: begin
                            state_nxt_s = ST_DONE;
                        end
                    endcase
                end else if (cnt_r >= WDOG_LAST) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    cnt_nxt_s = sat_inc(cnt_r);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            ST_ERR: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered outputs and port owner.
    always_comb begin
        accept_s  = (state_r == ST_IDLE) && en;
        launch_s  = (state_r == ST_ARM) && (state_nxt_s == ST_ACK);

        rdy_nxt_s = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_DONE);

        if (state_nxt_s == ST_ERR) begin
            err_nxt_s = 1'b1;
        end else if (accept_s) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end

        init_en_nxt_s = launch_s && (stage_r == SEL_INIT);
        ksa_en_nxt_s  = launch_s && (stage_r == SEL_KSA);
        prga_en_nxt_s = launch_s && (stage_r == SEL_PRGA);

        // Owner moves only with a start pulse, so the finishing engine keeps
        // the port until the next engine is launched.
        if ((state_nxt_s == ST_IDLE) || (state_nxt_s == ST_DONE) ||
            (state_nxt_s == ST_ERR)) begin
            owner_nxt_s = SEL_NONE;
        end else if (launch_s) begin
            owner_nxt_s = stage_r;
        end else begin
            owner_nxt_s = owner_r;
        end

        // Phase holds the failing stage while in ERR.
        if ((state_nxt_s == ST_IDLE) || (state_nxt_s == ST_DONE)) begin
            phase_nxt_s = SEL_NONE;
        end else if (launch_s) begin
            phase_nxt_s = stage_r;
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Registered outputs and port owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_r     <= 1'b1;
            err_r     <= 1'b0;
            phase_r   <= SEL_NONE;
            owner_r   <= SEL_NONE;
            init_en_r <= 1'b0;
            ksa_en_r  <= 1'b0;
            prga_en_r <= 1'b0;
        end else begin
            rdy_r     <= rdy_nxt_s;
            err_r     <= err_nxt_s;
            phase_r   <= phase_nxt_s;
            owner_r   <= owner_nxt_s;
            init_en_r <= init_en_nxt_s;
            ksa_en_r  <= ksa_en_nxt_s;
            prga_en_r <= prga_en_nxt_s;
        end
    end

    // S memory port mux on the registered owner; non-owners are ignored.
    always_comb begin
        s_addr   = 8'd0;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;
        case (owner_r)
            SEL_INIT: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
            end
            SEL_KSA: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
            end
            SEL_PRGA: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
            end
            default: begin
                s_addr   = 8'd0;
                s_wrdata = 8'd0;
                s_wren   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_arc4_sched.sv
// Testbench for arc4_sched: engine models, start-pulse and phase scoreboards,
// S-port routing monitor and a linear sequence of directed scenarios.
// Two instances: dut_a with default limits, dut_w with WDOG_CYCLES=100.

module tb_arc4_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic en_drv;
    logic sel_w;
    logic en_a;
    logic en_w;

    assign en_a = en_drv & ~sel_w;
    assign en_w = en_drv & sel_w;

    // Engine models: index 0 init, 1 ksa, 2 prga
    logic       eng_rdy    [3];
    logic       eng_busy   [3];
    int         eng_cnt    [3];
    int         eng_len    [3];
    logic       eng_noack  [3];
    logic       eng_nofin  [3];
    logic       eng_en     [3];
    logic [7:0] eng_addr   [3];
    logic [7:0] eng_wrdata [3];
    logic       eng_wren   [3];

    logic       a_rdy, a_err, a_init_en, a_ksa_en, a_prga_en, a_s_wren;
    logic [1:0] a_phase;
    logic [7:0] a_s_addr, a_s_wrdata;
    logic       w_rdy, w_err, w_init_en, w_ksa_en, w_prga_en, w_s_wren;
    logic [1:0] w_phase;
    logic [7:0] w_s_addr, w_s_wrdata;

    arc4_sched dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .rdy(a_rdy), .err(a_err), .phase(a_phase),
        .init_en(a_init_en), .ksa_en(a_ksa_en), .prga_en(a_prga_en),
        .init_rdy(eng_rdy[0]), .ksa_rdy(eng_rdy[1]), .prga_rdy(eng_rdy[2]),
        .init_addr(eng_addr[0]), .ksa_addr(eng_addr[1]), .prga_addr(eng_addr[2]),
        .init_wrdata(eng_wrdata[0]), .ksa_wrdata(eng_wrdata[1]), .prga_wrdata(eng_wrdata[2]),
        .init_wren(eng_wren[0]), .ksa_wren(eng_wren[1]), .prga_wren(eng_wren[2]),
        .s_addr(a_s_addr), .s_wrdata(a_s_wrdata), .s_wren(a_s_wren)
    );

    arc4_sched #(.WDOG_CYCLES(100), .ACK_CYCLES(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en_w), .rdy(w_rdy), .err(w_err), .phase(w_phase),
        .init_en(w_init_en), .ksa_en(w_ksa_en), .prga_en(w_prga_en),
        .init_rdy(eng_rdy[0]), .ksa_rdy(eng_rdy[1]), .prga_rdy(eng_rdy[2]),
        .init_addr(eng_addr[0]), .ksa_addr(eng_addr[1]), .prga_addr(eng_addr[2]),
        .init_wrdata(eng_wrdata[0]), .ksa_wrdata(eng_wrdata[1]), .prga_wrdata(eng_wrdata[2]),
        .init_wren(eng_wren[0]), .ksa_wren(eng_wren[1]), .prga_wren(eng_wren[2]),
        .s_addr(w_s_addr), .s_wrdata(w_s_wrdata), .s_wren(w_s_wren)
    );

    // Observed signals of the instance currently under test
    logic       m_rdy, m_err, m_init_en, m_ksa_en, m_prga_en, m_s_wren;
    logic [1:0] m_phase;
    logic [7:0] m_s_addr, m_s_wrdata;

    assign m_rdy      = sel_w ? w_rdy      : a_rdy;
    assign m_err      = sel_w ? w_err      : a_err;
    assign m_phase    = sel_w ? w_phase    : a_phase;
    assign m_init_en  = sel_w ? w_init_en  : a_init_en;
    assign m_ksa_en   = sel_w ? w_ksa_en   : a_ksa_en;
    assign m_prga_en  = sel_w ? w_prga_en  : a_prga_en;
    assign m_s_addr   = sel_w ? w_s_addr   : a_s_addr;
    assign m_s_wrdata = sel_w ? w_s_wrdata : a_s_wrdata;
    assign m_s_wren   = sel_w ? w_s_wren   : a_s_wren;

    always_comb begin
        eng_en[0] = m_init_en;
        eng_en[1] = m_ksa_en;
        eng_en[2] = m_prga_en;
    end

    // Engine memory traffic: distinct patterns while busy, a decoy pattern when idle
    always_comb begin
        eng_addr[0]   = eng_busy[0] ? eng_cnt[0][7:0]          : 8'hAA;
        eng_addr[1]   = eng_busy[1] ? ~eng_cnt[1][7:0]         : 8'hAA;
        eng_addr[2]   = eng_busy[2] ? (eng_cnt[2][7:0] ^ 8'h3C) : 8'hAA;
        eng_wrdata[0] = eng_busy[0] ? (eng_cnt[0][7:0] + 8'd1) : 8'h55;
        eng_wrdata[1] = eng_busy[1] ? (eng_cnt[1][7:0] + 8'd7) : 8'h55;
        eng_wrdata[2] = eng_busy[2] ? (eng_cnt[2][7:0] ^ 8'hC3) : 8'h55;
        for (int e = 0; e < 3; e++) begin
            eng_wren[e] = eng_busy[e] ? eng_cnt[e][0] : 1'b1;
        end
    end

    // Engine handshake behaviour
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < 3; e++) begin
                eng_rdy[e]  <= 1'b1;
                eng_busy[e] <= 1'b0;
                eng_cnt[e]  <= 0;
            end
        end else begin
            for (int e = 0; e < 3; e++) begin
                if (eng_en[e] && !eng_noack[e]) begin
                    eng_rdy[e]  <= 1'b0;
                    eng_busy[e] <= 1'b1;
                    eng_cnt[e]  <= 0;
                end else if (eng_busy[e]) begin
                    if (!eng_nofin[e] && (eng_cnt[e] >= eng_len[e] - 1)) begin
                        eng_rdy[e]  <= 1'b1;
                        eng_busy[e] <= 1'b0;
                    end else begin
                        eng_cnt[e] <= eng_cnt[e] + 1;
                    end
                end
            end
        end
    end

    int tests;
    int fails;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboards
    logic [1:0] en_q    [$];
    logic [1:0] phase_q [$];
    logic [1:0] phase_prev = 2'd0;
    logic       sb_on;
    logic       mon_on;

    // Start-pulse order, phase sequence and S-port routing monitor
    always @(negedge clk) begin
        logic [2:0] pulses;
        logic [1:0] id;
        pulses = {m_prga_en, m_ksa_en, m_init_en};
        if (sb_on) begin
            if (pulses != 3'd0) begin
                id = m_init_en ? 2'd1 : (m_ksa_en ? 2'd2 : 2'd3);
                check("en_onehot", 32'($countones(pulses)), 32'd1);
                if (en_q.size() == 0) begin
                    check("en_unexpected", 32'(id), 32'd0);
                end else begin
                    check("en_order", 32'(id), 32'(en_q.pop_front()));
                end
            end
            if (m_phase !== phase_prev) begin
                if (phase_q.size() == 0) begin
                    check("phase_unexpected", 32'(m_phase), 32'(phase_prev));
                end else begin
                    check("phase_seq", 32'(m_phase), 32'(phase_q.pop_front()));
                end
            end
            if (mon_on) begin
                for (int e = 0; e < 3; e++) begin
                    if (eng_busy[e]) begin
                        check("mux_addr", 32'(m_s_addr), 32'(eng_addr[e]));
                        check("mux_wren", 32'(m_s_wren), 32'(eng_wren[e]));
                    end
                end
            end
        end
        phase_prev <= m_phase;
    end

    task automatic start_and_check_latency();
        en_drv = 1'b1;
        @(negedge clk);
        en_drv = 1'b0;
        check("arm_no_pulse", 32'(m_init_en), 32'd0);
        check("accept_rdy_low", 32'(m_rdy), 32'd0);
        check("accept_err_clr", 32'(m_err), 32'd0);
        @(negedge clk);
        check("latency_init_en", 32'(m_init_en), 32'd1);
    endtask

    task automatic wait_busy(input int e, input int max);
        int n = 0;
        while (!eng_busy[e] && n < max) begin
            @(negedge clk);
            n++;
        end
        check("busy_wait", 32'(eng_busy[e]), 32'd1);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (m_rdy !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("done_wait", 32'(m_rdy), 32'd1);
    endtask

    task automatic check_idle_end(input string tag);
        @(negedge clk);
        check({tag, "_rdy"}, 32'(m_rdy), 32'd1);
        check({tag, "_err"}, 32'(m_err), 32'd0);
        check({tag, "_phase"}, 32'(m_phase), 32'd0);
        check({tag, "_s_wren"}, 32'(m_s_wren), 32'd0);
        check({tag, "_s_addr"}, 32'(m_s_addr), 32'd0);
        check({tag, "_en_q"}, 32'(en_q.size()), 32'd0);
        check({tag, "_phase_q"}, 32'(phase_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        int cyc;
        tests  = 0;
        fails  = 0;
        sb_on  = 1'b0;
        mon_on = 1'b0;
        sel_w  = 1'b0;
        en_drv = 1'b0;
        rst_n  = 1'b0;
        eng_len[0] = 256;
        eng_len[1] = 768;
        eng_len[2] = 300;
        for (int e = 0; e < 3; e++) begin
            eng_noack[e] = 1'b0;
            eng_nofin[e] = 1'b0;
        end

        // Reset with engines driving wren=1
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_wren", 32'(a_s_wren), 32'd0);
        check("rst_s_addr", 32'(a_s_addr), 32'd0);
        check("rst_rdy", 32'(a_rdy), 32'd1);
        check("rst_err", 32'(a_err), 32'd0);
        check("rst_phase", 32'(a_phase), 32'd0);
        check("rst_init_en", 32'(a_init_en), 32'd0);
        rst_n = 1'b1;
        sb_on = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal run, mux isolation and ignored en
        en_q.push_back(2'd1); en_q.push_back(2'd2); en_q.push_back(2'd3);
        phase_q.push_back(2'd1); phase_q.push_back(2'd2);
        phase_q.push_back(2'd3); phase_q.push_back(2'd0);
        mon_on = 1'b1;
        start_and_check_latency();
        wait_busy(1, 2000);
        repeat (50) @(negedge clk);
        check("iso_addr", 32'(m_s_addr), 32'(eng_addr[1]));
        check("iso_wrdata", 32'(m_s_wrdata), 32'(eng_wrdata[1]));
        check("iso_wren", 32'(m_s_wren), 32'(eng_wren[1]));
        en_drv = 1'b1;
        @(negedge clk);
        en_drv = 1'b0;
        check("ignored_en_rdy", 32'(m_rdy), 32'd0);
        check("ignored_en_phase", 32'(m_phase), 32'd2);
        wait_idle(3000);
        check_idle_end("nominal");
        mon_on = 1'b0;

        // Watchdog on the WDOG_CYCLES=100 instance
        sel_w = 1'b1;
        for (int e = 0; e < 3; e++) eng_len[e] = 30;
        eng_nofin[1] = 1'b1;
        en_q.push_back(2'd1); en_q.push_back(2'd2);
        phase_q.push_back(2'd1); phase_q.push_back(2'd2); phase_q.push_back(2'd0);
        start_and_check_latency();
        n = 0;
        while (!m_ksa_en && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("wdog_ksa_en_seen", 32'(m_ksa_en), 32'd1);
        cyc = 0;
        while (!m_err && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("wdog_cycles", 32'(cyc), 32'd102);
        check("wdog_phase", 32'(m_phase), 32'd2);
        check("wdog_rdy_in_err", 32'(m_rdy), 32'd0);
        @(negedge clk);
        check("wdog_rdy_after", 32'(m_rdy), 32'd1);
        check("wdog_err_sticky", 32'(m_err), 32'd1);
        eng_nofin[1] = 1'b0;
        repeat (3) @(negedge clk);
        check("wdog_err_held", 32'(m_err), 32'd1);
        check("wdog_en_q", 32'(en_q.size()), 32'd0);
        en_q.push_back(2'd1); en_q.push_back(2'd2); en_q.push_back(2'd3);
        phase_q.push_back(2'd1); phase_q.push_back(2'd2);
        phase_q.push_back(2'd3); phase_q.push_back(2'd0);
        en_drv = 1'b1;
        @(negedge clk);
        en_drv = 1'b0;
        check("wdog_err_cleared", 32'(m_err), 32'd0);
        wait_idle(2000);
        check_idle_end("wdog_rerun");

        // ACK timeout: init never drops rdy
        sel_w = 1'b0;
        eng_len[0] = 256;
        eng_len[1] = 768;
        eng_len[2] = 300;
        eng_noack[0] = 1'b1;
        en_q.push_back(2'd1);
        phase_q.push_back(2'd1); phase_q.push_back(2'd0);
        start_and_check_latency();
        cyc = 0;
        while (!m_err && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("ack_cycles", 32'(cyc), 32'd4);
        check("ack_phase", 32'(m_phase), 32'd1);
        @(negedge clk);
        check("ack_rdy_after", 32'(m_rdy), 32'd1);
        check("ack_en_q", 32'(en_q.size()), 32'd0);
        eng_noack[0] = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of KSA
        en_q.push_back(2'd1); en_q.push_back(2'd2);
        phase_q.push_back(2'd1); phase_q.push_back(2'd2); phase_q.push_back(2'd0);
        mon_on = 1'b1;
        start_and_check_latency();
        wait_busy(1, 2000);
        repeat (10) @(negedge clk);
        check("midksa_wren_before", 32'(m_s_wren), 32'(eng_wren[1]));
        mon_on = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_s_wren", 32'(a_s_wren), 32'd0);
        check("midrst_s_addr", 32'(a_s_addr), 32'd0);
        check("midrst_rdy", 32'(a_rdy), 32'd1);
        check("midrst_phase", 32'(a_phase), 32'd0);
        check("midrst_ksa_en", 32'(a_ksa_en), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_en_q", 32'(en_q.size()), 32'd0);
        check("midrst_phase_q", 32'(phase_q.size()), 32'd0);
        @(negedge clk);

        // Fresh start after reset begins again from init
        en_q.push_back(2'd1); en_q.push_back(2'd2); en_q.push_back(2'd3);
        phase_q.push_back(2'd1); phase_q.push_back(2'd2);
        phase_q.push_back(2'd3); phase_q.push_back(2'd0);
        mon_on = 1'b1;
        start_and_check_latency();
        wait_idle(3000);
        check_idle_end("restart");
        mon_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
